// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage in front of the IF/ID register.
//
// Keeps the PC and issues one instruction-cache request at a time. A
// direct-mapped branch-target buffer (BTB) with 2-bit counters supplies the
// next PC. A fetched word is held until the PC stage is released. A flush
// from EX redirects the PC. If a response is still in flight when the flush
// arrives, that response is discarded.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall[STALL_W-1:0]       pipeline stall vector, bit 0 freezes the PC stage
//   flush, flush_target      redirect from EX
//   icache_req/icache_addr   level request and address to the cache
//   icache_valid/icache_inst one-cycle response strobe and data
//   br_update, br_pc,
//   br_taken, br_target      resolved branch used to train the BTB
//   if_pc, if_npc, if_inst,
//   if_prediction            fetched instruction bundle for IF/ID
//   if_stall_req             high while no valid word is held
module if_fetch #(
    parameter int ADDR_W   = 32,
    parameter int INST_W   = 32,
    parameter int BTB_IDX  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_target,
    output logic               icache_req,
    output logic [ADDR_W-1:0]  icache_addr,
    input  logic               icache_valid,
    input  logic [INST_W-1:0]  icache_inst,
    input  logic               br_update,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_npc,
    output logic [INST_W-1:0]  if_inst,
    output logic [ADDR_W-1:0]  if_prediction,
    output logic               if_stall_req
);

    localparam int BTB_N = 1 << BTB_IDX;
    localparam int TAG_W = ADDR_W - BTB_IDX - 2;
    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_READY   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pred_q, pred_d;

    logic                btb_vld_q [BTB_N];
    logic                btb_vld_d [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q [BTB_N];
    logic [TAG_W-1:0]    btb_tag_d [BTB_N];
    logic [ADDR_W-1:0]   btb_tgt_q [BTB_N];
    logic [ADDR_W-1:0]   btb_tgt_d [BTB_N];
    logic [1:0]          btb_ctr_q [BTB_N];
    logic [1:0]          btb_ctr_d [BTB_N];

    logic [ADDR_W-1:0]   pc_plus4;
    logic [BTB_IDX-1:0]  lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [ADDR_W-1:0]   lk_pred;
    logic [BTB_IDX-1:0]  up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    logic                unused_bits;

    assign unused_bits = ^{stall[STALL_W-1:1], br_pc[1:0]};

    // Lookup reads only the registered BTB, so an update to the same index
    // in this cycle is not seen until the next cycle.
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign lk_idx   = pc_q[BTB_IDX+1:2];
    assign lk_tag   = pc_q[ADDR_W-1:BTB_IDX+2];
    assign lk_pred  = (btb_vld_q[lk_idx] && btb_tag_q[lk_idx] == lk_tag && btb_ctr_q[lk_idx][1])
                      ? btb_tgt_q[lk_idx] : pc_plus4;

    assign up_idx   = br_pc[BTB_IDX+1:2];
    assign up_tag   = br_pc[ADDR_W-1:BTB_IDX+2];
    assign up_hit   = btb_vld_q[up_idx] && btb_tag_q[up_idx] == up_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pred_q  <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pred_q  <= pred_d;
            for (int i = 0; i < BTB_N; i++) begin
                btb_vld_q[i] <= btb_vld_d[i];
                btb_tag_q[i] <= btb_tag_d[i];
                btb_tgt_q[i] <= btb_tgt_d[i];
                btb_ctr_q[i] <= btb_ctr_d[i];
            end
        end
    end

    // Fetch state machine: next state, PC and held word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pred_d  = pred_q;
        if (flush) begin
            pc_d = flush_target;
            // A request still open with no response this cycle will be
            // answered later, and that answer must be dropped.
            if ((state_q == S_FETCH || state_q == S_DISCARD) && !icache_valid)
                state_d = S_DISCARD;
            else
                state_d = S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (icache_valid) begin
                        inst_d  = icache_inst;
                        pred_d  = lk_pred;
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (!stall[0]) begin
                        pc_d    = pred_q;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (icache_valid)
                        state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // BTB training, independent of flush.
    always_comb begin
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        btb_ctr_d = btb_ctr_q;
        if (br_update) begin
            if (up_hit) begin
                if (br_taken) begin
                    btb_tgt_d[up_idx] = br_target;
                    if (btb_ctr_q[up_idx] != 2'b11)
                        btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'b01;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'b01;
                end
            end else if (br_taken) begin
                btb_vld_d[up_idx] = 1'b1;
                btb_tag_d[up_idx] = up_tag;
                btb_tgt_d[up_idx] = br_target;
                btb_ctr_d[up_idx] = 2'b10;
            end
        end
    end

    // Outputs to the cache and to IF/ID.
    always_comb begin
        icache_req    = (state_q == S_FETCH);
        icache_addr   = pc_q;
        if_stall_req  = (state_q != S_READY);
        if_pc         = '0;
        if_npc        = '0;
        if_inst       = NOP;
        if_prediction = '0;
        if (state_q == S_READY && !flush) begin
            if_pc         = pc_q;
            if_npc        = pc_plus4;
            if_inst       = inst_q;
            if_prediction = pred_q;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: the bench plays the instruction cache and
// EX stage, and compares outputs against hand-computed values.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        br_update;
    logic [31:0] br_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] if_pc, if_npc, if_inst, if_prediction;
    logic        if_stall_req;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch #(
        .ADDR_W(32), .INST_W(32), .BTB_IDX(4), .RESET_PC(32'h0), .STALL_W(6)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .flush_target(flush_target), .icache_req(icache_req),
        .icache_addr(icache_addr), .icache_valid(icache_valid),
        .icache_inst(icache_inst), .br_update(br_update), .br_pc(br_pc),
        .br_taken(br_taken), .br_target(br_target), .if_pc(if_pc),
        .if_npc(if_npc), .if_inst(if_inst), .if_prediction(if_prediction),
        .if_stall_req(if_stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle cache response.
    task automatic serve(input logic [31:0] inst);
        icache_valid = 1'b1;
        icache_inst  = inst;
        step();
        icache_valid = 1'b0;
        icache_inst  = '0;
    endtask

    // Flush coinciding with a response: always lands directly in FETCH.
    task automatic redirect(input logic [31:0] tgt);
        flush = 1'b1;
        flush_target = tgt;
        icache_valid = 1'b1;
        icache_inst  = 32'hBAD0_BAD0;
        step();
        flush = 1'b0;
        icache_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; flush_target = '0;
        icache_valid = 1'b0; icache_inst = '0;
        br_update = 1'b0; br_pc = '0; br_taken = 1'b0; br_target = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_req", {31'b0, icache_req}, 32'd1);
        check("rst_addr", icache_addr, 32'h0);
        check("rst_inst", if_inst, NOP);
        check("rst_pc", if_pc, 32'h0);
        check("rst_stallreq", {31'b0, if_stall_req}, 32'd1);

        // First fetch, cache answers after 2 cycles
        step(); step();
        check("f0_addr_stable", icache_addr, 32'h0);
        serve(32'h0050_0093);
        check("f0_pc", if_pc, 32'h0);
        check("f0_npc", if_npc, 32'h4);
        check("f0_inst", if_inst, 32'h0050_0093);
        check("f0_pred", if_prediction, 32'h4);
        check("f0_stallreq", {31'b0, if_stall_req}, 32'd0);

        // Hold in READY for 3 cycles
        stall = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req", {31'b0, icache_req}, 32'd0);
            check("hold_inst", if_inst, 32'h0050_0093);
        end
        stall = '0;
        step();
        check("rel_addr", icache_addr, 32'h4);
        check("rel_req", {31'b0, icache_req}, 32'd1);

        // Train BTB: 0x10 taken -> 0x40
        br_update = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_target = 32'h40;
        step();
        br_update = 1'b0;
        check("f4_addr_stable", icache_addr, 32'h4);
        serve(32'h11);
        check("f4_pc", if_pc, 32'h4);
        check("f4_pred", if_prediction, 32'h8);
        step();
        check("f8_addr", icache_addr, 32'h8);

        // Flush while a fetch at 0x8 is outstanding
        flush = 1'b1; flush_target = 32'h80;
        step();
        flush = 1'b0;
        check("disc_req", {31'b0, icache_req}, 32'd0);
        check("disc_stallreq", {31'b0, if_stall_req}, 32'd1);
        serve(32'hDEAD_BEEF);
        check("disc_inst", if_inst, NOP);
        check("disc_req_after", {31'b0, icache_req}, 32'd1);
        check("disc_addr_after", icache_addr, 32'h80);

        // Fetch 0x10 predicts taken
        redirect(32'h10);
        check("r10_addr", icache_addr, 32'h10);
        serve(32'h44);
        check("t10_pc", if_pc, 32'h10);
        check("t10_npc", if_npc, 32'h14);
        check("t10_pred", if_prediction, 32'h40);
        step();
        check("t10_next_addr", icache_addr, 32'h40);

        // Two not-taken updates at 0x10 (second with a redirect to 0x10)
        br_update = 1'b1; br_pc = 32'h10; br_taken = 1'b0; br_target = '0;
        step();
        redirect(32'h10);
        br_update = 1'b0;
        check("nt_addr", icache_addr, 32'h10);
        serve(32'h66);
        check("nt_pred", if_prediction, 32'h14);

        // Flush in READY with a simultaneous BTB update at 0x20
        flush = 1'b1; flush_target = 32'h100;
        br_update = 1'b1; br_pc = 32'h20; br_taken = 1'b1; br_target = 32'h300;
        #1;
        check("frdy_inst", if_inst, NOP);
        check("frdy_pc", if_pc, 32'h0);
        check("frdy_pred", if_prediction, 32'h0);
        step();
        flush = 1'b0; br_update = 1'b0;
        check("frdy_addr", icache_addr, 32'h100);
        check("frdy_req", {31'b0, icache_req}, 32'd1);
        redirect(32'h20);
        serve(32'h77);
        check("upd20_pred", if_prediction, 32'h300);

        // Aliasing: retrain 0x10 to strong-ish taken, then fetch 0x50
        br_update = 1'b1; br_pc = 32'h10; br_taken = 1'b1; br_target = 32'h40;
        flush = 1'b1; flush_target = 32'h50;
        step();
        flush = 1'b0;
        step();
        br_update = 1'b0;
        check("al_addr", icache_addr, 32'h50);
        serve(32'h88);
        check("al_pc", if_pc, 32'h50);
        check("al_pred", if_prediction, 32'h54);
        flush = 1'b1; flush_target = 32'h10;
        step();
        flush = 1'b0;
        serve(32'h99);
        check("al10_pred", if_prediction, 32'h40);

        // PC wrap at the top of the address space
        flush = 1'b1; flush_target = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        serve(32'hAA);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_npc", if_npc, 32'h0);
        check("wrap_pred", if_prediction, 32'h0);

        // Reset from READY clears state and BTB
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_addr", icache_addr, 32'h0);
        check("rst2_req", {31'b0, icache_req}, 32'd1);
        check("rst2_inst", if_inst, NOP);
        redirect(32'h10);
        serve(32'hBB);
        check("rst2_btb_pred", if_prediction, 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
